// File: rtl/soc_gpio_input_filter.sv
// GPIO pad input conditioning: per-pin synchronizer, debounce counter,
// filtered level register and registered one-cycle rise/fall pulses.
module soc_gpio_input_filter #(
  parameter int unsigned PIN_COUNT       = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [PIN_COUNT-1:0] pins_in,
  input  logic [PIN_COUNT-1:0] bypass,
  output logic [PIN_COUNT-1:0] gpio_in,
  output logic [PIN_COUNT-1:0] rise,
  output logic [PIN_COUNT-1:0] fall
);

  localparam int unsigned CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PIN_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [PIN_COUNT-1:0] synced;

  logic [CNT_W-1:0]     cnt_q [PIN_COUNT];
  logic [CNT_W-1:0]     cnt_d [PIN_COUNT];
  logic [PIN_COUNT-1:0] gpio_q;
  logic [PIN_COUNT-1:0] gpio_d;
  logic [PIN_COUNT-1:0] rise_q;
  logic [PIN_COUNT-1:0] fall_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Plain shift chain into the clock domain; no logic between stages.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {PIN_COUNT{RESET_VALUE}};
      end
    end else begin
      sync_q[0] <= pins_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Debounce decision per pin: accept a new level after it persists long enough.
  always_comb begin
    gpio_d = gpio_q;
    for (int unsigned j = 0; j < PIN_COUNT; j++) begin
      cnt_d[j] = '0;
      if (bypass[j]) begin
        gpio_d[j] = synced[j];
      end else if (synced[j] != gpio_q[j]) begin
        if (cnt_q[j] == CNT_LAST) begin
          gpio_d[j] = synced[j];
        end else begin
          cnt_d[j] = cnt_q[j] + 1'b1;
        end
      end
    end
  end

  // Filtered level, counters and edge pulses; reset overrides any acceptance.
  always_ff @(posedge clk) begin
    if (res) begin
      gpio_q <= {PIN_COUNT{RESET_VALUE}};
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned j = 0; j < PIN_COUNT; j++) begin
        cnt_q[j] <= '0;
      end
    end else begin
      gpio_q <= gpio_d;
      rise_q <= ~gpio_q & gpio_d;
      fall_q <= gpio_q & ~gpio_d;
      for (int unsigned j = 0; j < PIN_COUNT; j++) begin
        cnt_q[j] <= cnt_d[j];
      end
    end
  end

  assign gpio_in = gpio_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: doc/soc_gpio_input_filter.md
# soc_gpio_input_filter

Input conditioning stage between the external GPIO pads and the `gpio_in` bus of the SoC GPIO controller. Each pin gets a multi-flop synchronizer, then a per-pin debounce counter. The filtered level is driven onto `gpio_in`, so glitches and bounce never reach the change-notification logic. One-cycle rise/fall pulses per pin are provided for debug and for other consumers.

## Interface
Parameters:
- `PIN_COUNT`, default 32: number of pins filtered; normally 32*PORT_COUNT of the GPIO controller.
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a new level must persist before acceptance; legal 1..65535.
- `RESET_VALUE`, default 0: 1-bit level loaded into every sync flop and filtered output on reset.

Ports:
- `clk` input 1: single clock; all state is clocked on its rising edge.
- `res` input 1: reset, synchronous and active-high.
- `pins_in` input PIN_COUNT: raw asynchronous pad levels.
- `bypass` input PIN_COUNT: per-pin debounce bypass, quasi-static. When 1, the pin skips the debounce counter but not the synchronizer.
- `gpio_in` output PIN_COUNT: filtered levels; connects to the GPIO controller `gpio_in`.
- `rise` output PIN_COUNT: one-cycle pulse in the cycle after `gpio_in[j]` goes 0->1.
- `fall` output PIN_COUNT: one-cycle pulse in the cycle after `gpio_in[j]` goes 1->0.

## Operation
- Pins are fully independent; the description below applies to each pin j.
- **Synchronizer:** a shift chain of SYNC_STAGES flops. `synced` is the last stage. There is no logic between stages.
- **Debounce state:**
  - `gpio_in[j]` is a register.
  - `cnt` is an unsigned counter of width $clog2(DEBOUNCE_CYCLES+1), minimum 1 bit.
- **Per cycle, not bypassed:**
  - If `synced == gpio_in[j]`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `gpio_in[j] <= synced`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any return of `synced` to the current output level restarts the count from 0. Bounce shorter than DEBOUNCE_CYCLES is therefore fully suppressed.
- **Bypassed:**
  - `gpio_in[j] <= synced` every cycle; `cnt <= 0`.
  - Toggling `bypass` mid-count is legal. Asserting it forces `cnt` to 0 and the output follows `synced` next cycle. Deasserting it resumes normal counting from `cnt = 0`.
- **Edge pulses:**
  - `rise[j] <= ~gpio_in[j] & next_gpio_in[j]`.
  - `fall[j] <= gpio_in[j] & ~next_gpio_in[j]`.
  - Both are registered, so each pulse is high exactly one cycle, aligned with the cycle in which `gpio_in` shows the new level.
  - `rise` and `fall` are never high simultaneously on the same pin.
- **Reset (synchronous):**
  - All sync flops and `gpio_in` load RESET_VALUE.
  - `cnt`, `rise` and `fall` load 0.
  - Reset has priority over all other updates, including a pending acceptance in the same cycle.
  - Reset mid-count discards the count; no edge pulse is generated by reset itself.
- **Counter limits:** `cnt` never exceeds DEBOUNCE_CYCLES-1, so no wrap-around can occur.
- **Degenerate setting:** DEBOUNCE_CYCLES = 1 behaves identically to bypass.

## Timing
- Reset values: `gpio_in` = {PIN_COUNT{RESET_VALUE}}, `rise` = 0, `fall` = 0.
- Let the pad change be stable before edge 0. Then:
  - `synced` changes after edge SYNC_STAGES-1.
  - `gpio_in` changes after edge SYNC_STAGES-1+DEBOUNCE_CYCLES.
  - Total latency is SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles from the first sampling edge.
  - With defaults, 17 cycles.
- Bypassed latency: SYNC_STAGES cycles.
- `rise`/`fall` assert in the same cycle `gpio_in` first shows the new level and deassert the next cycle.
- Minimum spacing between accepted transitions on one pin: DEBOUNCE_CYCLES cycles (non-bypassed).
- No combinational path from any input to any output.

## Test plan
- **Reset:**
  - Stimulus: RESET_VALUE=0, `pins_in` all 1, `res` high for 3 cycles.
  - Required: during reset, `gpio_in` = 0, `rise` = 0, `fall` = 0. After release with defaults, `gpio_in` goes 1 after exactly 17 cycles and `rise` is all-ones for exactly 1 cycle.
- **Glitch rejection:**
  - Stimulus: pin 3 pulsed high for 15 cycles (DEBOUNCE_CYCLES=16), then low.
  - Required: `gpio_in[3]` stays 0 and `rise[3]` is never asserted.
- **Bounce then settle:**
  - Stimulus: pin 0 toggled 1,0,1,0,1 with 3-cycle widths, then held 1.
  - Required: `gpio_in[0]` goes 1 exactly 16 cycles after `synced` last rose, with a single `rise[0]` pulse.
- **Bypass:**
  - Stimulus: `bypass[5]`=1, 1-cycle pulse on pin 5.
  - Required: `gpio_in[5]` shows the pulse 2 cycles later for 1 cycle; `rise[5]` and `fall[5]` pulse on consecutive cycles.
  - Stimulus: deassert bypass mid-count.
  - Required: the count restarts from 0.
- **Reset mid-count:**
  - Stimulus: pin 7 high, `res` asserted when `cnt` = 10, released, pin held high.
  - Required: `gpio_in[7]` rises 17 cycles after release, not earlier; no `fall` pulse at any point.
- **Independence:**
  - Stimulus: PIN_COUNT=64, random per-pin bounce patterns and bypass settings.
  - Required: a scoreboard model matches `gpio_in`, `rise` and `fall` every cycle; `rise` & `fall` is never nonzero on any pin.
